// File: rtl/data_sram_resp.sv
// Responder for the CPU data-SRAM port: byte-lane RAM with 1-cycle read and a post-reset clear sweep.
// Optional access statistics are built when DSRAM_ACCESS_STATS_EN is defined.

// One byte lane: write port plus a registered read port. The read register is reset; the array is not.
module data_sram_resp_lane #(
  parameter int AW    = 10,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_idx,
  input  logic [VEC_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [AW-1:0]    rd_idx,
  output logic [VEC_W-1:0] rd_data
);
  logic [VEC_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Read register holds between accesses; an out-of-range read zeroes it.
  always_ff @(posedge clk) begin
    if (reset)       rd_data <= '0;
    else if (rd_clr) rd_data <= '0;
    else if (rd_en)  rd_data <= mem[rd_idx];
  end
endmodule

module data_sram_resp #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_done,
`ifdef DSRAM_ACCESS_STATS_EN
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt,
  output logic [31:0] last_wr_addr,
`endif
  output logic        oor_err
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  typedef struct packed {
    logic                              en;
    logic [NUM_LANES-1:0]              we;
    logic [31:0]                       addr;
    logic [NUM_LANES-1:0][VEC_W-1:0]   wdata;
  } req_t;

  req_t                            req;
  logic [0:0]                      state;
  logic [ADDR_W-1:0]               clear_ptr;
  logic [31:0]                     off;
  logic                            in_rng;
  logic [ADDR_W-1:0]               idx;
  logic                            clearing;
  logic                            acc, acc_wr, acc_rd;
  logic [ADDR_W-1:0]               wr_idx;
  logic [NUM_LANES-1:0]            lane_wr;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_wdata;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_q;
  logic                            unused_off;

  assign req.en    = data_sram_en;
  assign req.we    = data_sram_we;
  assign req.addr  = data_sram_addr;
  assign req.wdata = data_sram_wdata;

  // Subtraction wraps mod 2**32, so addresses below BASE_ADDR land far out of range.
  assign off        = req.addr - BASE_ADDR;
  assign in_rng     = (off[31:ADDR_W+2] == '0);
  assign idx        = off[ADDR_W+1:2];
  assign unused_off = ^off[1:0];

  assign clearing = (state == ST_CLEAR);
  assign acc      = !clearing && req.en;
  assign acc_wr   = acc && (req.we != '0);
  assign acc_rd   = acc && (req.we == '0);

  assign wr_idx = clearing ? clear_ptr : idx;

  always_comb begin
    lane_wr    = '0;
    lane_wdata = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_wr[i]    = clearing || (acc_wr && in_rng && req.we[i]);
      lane_wdata[i] = clearing ? '0 : req.wdata[i];
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    data_sram_resp_lane #(.AW(ADDR_W), .VEC_W(VEC_W)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (lane_wr[g]),
      .wr_idx  (wr_idx),
      .wr_data (lane_wdata[g]),
      .rd_en   (acc_rd && in_rng),
      .rd_clr  (acc_rd && !in_rng),
      .rd_idx  (idx),
      .rd_data (rd_q[g])
    );
  end

  assign data_sram_rdata = rd_q;

  // Clear sweep: one word per cycle; the last word written moves us to READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      clear_ptr <= '0;
    end else if (clearing) begin
      clear_ptr <= clear_ptr + 1'b1;
      if (&clear_ptr) state <= ST_READY;
    end
  end

  assign init_done = (state == ST_READY);

  always_ff @(posedge clk) begin
    if (reset)             oor_err <= 1'b0;
    else if (acc && !in_rng) oor_err <= 1'b1;
  end

`ifdef DSRAM_ACCESS_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rd_cnt  <= '0;
      stat_wr_cnt  <= '0;
      last_wr_addr <= '0;
    end else begin
      if (acc_rd && in_rng) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (acc_wr && in_rng) begin
        stat_wr_cnt  <= stat_wr_cnt + 32'd1;
        last_wr_addr <= req.addr;
      end
    end
  end
`endif
endmodule

// File: tb/tb_data_sram_resp.sv
// Randomised bench for data_sram_resp with a word-level reference model and directed scenarios.
module tb_data_sram_resp;
  localparam int          AW    = 4;
  localparam int          DEPTH = 2**AW;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        init_done;
  logic        oor_err;
`ifdef DSRAM_ACCESS_STATS_EN
  logic [31:0] stat_rd_cnt, stat_wr_cnt, last_wr_addr;
`endif

  int checks = 0;
  int errors = 0;

  data_sram_resp #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .init_done       (init_done),
`ifdef DSRAM_ACCESS_STATS_EN
    .stat_rd_cnt     (stat_rd_cnt),
    .stat_wr_cnt     (stat_wr_cnt),
    .last_wr_addr    (last_wr_addr),
`endif
    .oor_err         (oor_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words as a plain array, clear phase as a cycle count.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  bit          m_oor, m_ready, started;
  int          m_clr;
  logic [31:0] m_rd_cnt, m_wr_cnt, m_last;

  always @(posedge clk) begin
    logic [31:0] o;
    bit          inr;
    int          ix;
    started = 1;
    if (reset) begin
      m_clr = 0; m_ready = 0; m_rdata = 0; m_oor = 0;
      m_rd_cnt = 0; m_wr_cnt = 0; m_last = 0;
    end else if (!m_ready) begin
      m_clr++;
      if (m_clr == DEPTH) begin
        m_ready = 1;
        foreach (m_mem[i]) m_mem[i] = 32'h0;
      end
    end else if (en) begin
      o   = addr - BASE;
      inr = (o >> (AW + 2)) == 0;
      ix  = int'((o >> 2) % DEPTH);
      if (we != 4'h0) begin
        if (inr) begin
          for (int b = 0; b < 4; b++)
            if (we[b]) m_mem[ix][8*b +: 8] = wdata[8*b +: 8];
          m_wr_cnt++; m_last = addr;
        end else m_oor = 1;
      end else if (inr) begin
        m_rdata = m_mem[ix]; m_rd_cnt++;
      end else begin
        m_rdata = 0; m_oor = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rdata", rdata, m_rdata);
      chk("init_done", {31'h0, init_done}, {31'h0, m_ready});
      chk("oor_err", {31'h0, oor_err}, {31'h0, m_oor});
`ifdef DSRAM_ACCESS_STATS_EN
      chk("stat_rd_cnt", stat_rd_cnt, m_rd_cnt);
      chk("stat_wr_cnt", stat_wr_cnt, m_wr_cnt);
      chk("last_wr_addr", last_wr_addr, m_last);
`endif
    end
  end

  task automatic drive(input bit e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_init_done", {31'h0, init_done}, 32'h0);
    reset = 1'b0;

    n = 0;
    while (!init_done && n < 100) begin idle(); n++; end
    chk("clear_cycles", n, DEPTH);

    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 4'h0, i * 4, 32'h0);
      chk("cleared_word", rdata, 32'h0);
    end

    drive(1, 4'hF, 32'h8, 32'hDEAD_BEEF);
    drive(1, 4'h0, 32'h8, 32'h0);
    chk("wr_then_rd", rdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("hold", rdata, 32'hDEAD_BEEF);
    end

    drive(1, 4'hF, 32'h4, 32'h1122_3344);
    drive(1, 4'b0101, 32'h4, 32'hAABB_CCDD);
    drive(1, 4'h0, 32'h4, 32'h0);
    chk("partial_wr", rdata, 32'h11BB_33DD);

    drive(1, 4'hF, 32'h0, 32'd1);
    drive(1, 4'hF, 32'h4, 32'd2);
    drive(1, 4'hF, 32'h8, 32'd3);
    drive(1, 4'h0, 32'h0, 32'h0); chk("b2b_0", rdata, 32'd1);
    drive(1, 4'h0, 32'h4, 32'h0); chk("b2b_1", rdata, 32'd2);
    drive(1, 4'h0, 32'h8, 32'h0); chk("b2b_2", rdata, 32'd3);

    chk("oor_clean", {31'h0, oor_err}, 32'h0);
    drive(1, 4'hF, 32'h40, 32'hFFFF_FFFF);
    chk("oor_wr_flag", {31'h0, oor_err}, 32'h1);
    drive(1, 4'h0, 32'h40, 32'h0);
    chk("oor_rd_zero", rdata, 32'h0);
    drive(1, 4'h0, 32'h0, 32'h0);
    chk("oor_word0_intact", rdata, 32'd1);
    repeat (3) idle();
    chk("oor_sticky", {31'h0, oor_err}, 32'h1);

    // Random traffic; mostly in range, occasional out-of-range addresses.
    for (int i = 0; i < 3000; i++) begin
      a = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(AW + 2, 31));
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0,
            a, $urandom);
    end

    // Reset during the clear sweep restarts it from word 0.
    drive(1, 4'hF, 32'h0, 32'h5555_AAAA);
    reset = 1'b1; idle(); idle();
    chk("rst_oor_clear", {31'h0, oor_err}, 32'h0);
    reset = 1'b0;
    repeat (7) idle();
    reset = 1'b1; idle();
    reset = 1'b0;
    idle(); idle();
    drive(1, 4'hF, 32'h0, 32'h1234_5678);
    n = 3;
    while (!init_done && n < 100) begin idle(); n++; end
    chk("reclear_cycles", n, DEPTH);
    drive(1, 4'h0, 32'h0, 32'h0);
    chk("clear_write_ignored", rdata, 32'h0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder end of the CPU data-SRAM port (en / we[3:0] / addr / wdata / rdata) driven by the memory stage.
- Word-organised single-port RAM: byte-enable writes, synchronous read with 1-cycle latency, read data held between accesses.
- Post-reset hardware clear sequencer zeroes every word before accepting accesses.
- Out-of-range addresses are detected and dropped.

Parameters:
- ADDR_W, 10, word-index width; depth = 2**ADDR_W words (byte span 4*2**ADDR_W).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2**ADDR_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- data_sram_en  in  1  access request this cycle
- data_sram_we  in  4  byte write enables, bit i -> wdata[8i+7:8i]; 0 = read
- data_sram_addr  in  32  byte address; bits [1:0] ignored
- data_sram_wdata  in  32  write data
- data_sram_rdata  out  32  read data, valid the cycle after a read request
- init_done  out  1  high once the clear sequence has finished
- oor_err  out  1  sticky flag: an access hit an out-of-range address

Behaviour:
- Interface: one clock, synchronous active-high reset. All state updates on posedge clk.
- Reset (reset=1): FSM->CLEAR, clear_ptr=0, data_sram_rdata=0, init_done=0, oor_err=0.
  - RAM contents are not reset directly; the CLEAR state zeroes them.
  - Reset asserted mid-CLEAR or mid-READY restarts CLEAR from word 0.
- FSM states:
  - CLEAR: each cycle write 0 to word clear_ptr, then clear_ptr++.
    - When clear_ptr == 2**ADDR_W-1 is written, go to READY and set init_done=1 next cycle.
    - CLEAR lasts exactly 2**ADDR_W cycles after reset deasserts.
    - Requests in CLEAR are ignored: no write, rdata stays 0, oor_err not updated.
  - READY: serve requests. Terminal until reset.
- Address decode:
  - off = addr - BASE_ADDR.
  - In range iff off[31:ADDR_W+2]==0.
  - idx = off[ADDR_W+1:2].
- Write (READY, en=1, we!=0, in range):
  - For each i with we[i]=1, mem[idx] byte i <= wdata byte i.
  - Other bytes unchanged.
  - data_sram_rdata holds its previous value.
- Read (READY, en=1, we==0, in range):
  - data_sram_rdata <= mem[idx] at the next edge, so it is visible in cycle N+1 for a request in cycle N.
  - This matches the memory stage sampling rdata one cycle after issue.
- Back-to-back:
  - Reads every cycle are fully pipelined; one result per cycle.
  - Write to X in cycle N, then read X in cycle N+1, returns the new data.
  - No same-cycle read+write exists, since we!=0 means write.
- Hold: with en=0, data_sram_rdata keeps its last value indefinitely.
- Out of range (READY, en=1):
  - Write is dropped.
  - Read sets data_sram_rdata <= 0.
  - oor_err <= 1, sticky until reset.
- Width: wdata/rdata are 32 bits. addr wraps modulo 2**32 in the subtraction.

Optional Feature:
- Macro DSRAM_ACCESS_STATS_EN.
- Defined: adds outputs stat_rd_cnt[31:0] and stat_wr_cnt[31:0].
  - Each counts accepted in-range READY reads and writes; a partial-byte write counts once.
  - Both reset to 0 and wrap 0xFFFF_FFFF->0.
  - Also adds last_wr_addr[31:0], holding the byte address of the latest accepted write; reset 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle with ADDR_W=4 -> init_done low for exactly 16 cycles after reset falls, then high. Read of idx 0..15 returns 0x00000000.
- Write 0xDEADBEEF to 0x8 with we=4'hF, then next cycle read 0x8 -> rdata=0xDEADBEEF on the cycle after the read; hold en=0 for 5 cycles -> rdata stays 0xDEADBEEF.
- Partial write: word 0x4=0x11223344, write we=4'b0101 wdata=0xAABBCCDD, then read -> 0x11BB33DD.
- Back-to-back reads of 0x0,0x4,0x8 containing 1,2,3 -> rdata sequence 1,2,3 on consecutive cycles.
- With ADDR_W=4, BASE_ADDR=0: write to 0x40 -> dropped and oor_err=1; read 0x40 -> rdata=0; word 0 unchanged; oor_err stays 1 until reset.
- Assert reset during CLEAR at cycle 7, then write in the 3rd cycle after release -> write ignored; init_done rises exactly 2**ADDR_W cycles after reset falls.
